// File: rtl/q_result_fifo_if.sv
// Handshake bundle between the Q producer, the result FIFO and its consumer.
// The master modport is the traffic source/sink side; the FIFO uses the slave modport.
interface q_result_fifo_if #(
  parameter int Q_WIDTH = 35
);
  logic               in_valid;
  logic [Q_WIDTH-1:0] in_q;
  logic               out_valid;
  logic               out_ready;
  logic [Q_WIDTH-1:0] out_q;

  modport master (
    output in_valid, in_q, out_ready,
    input  out_valid, out_q
  );

  modport slave (
    input  in_valid, in_q, out_ready,
    output out_valid, out_q
  );
endinterface

// File: rtl/q_result_fifo.sv
// First-word-fall-through buffer for signed Q results with drop-on-full and sticky overflow.
// Optional push statistics (count/min/max) are enabled with the Q_FIFO_STATS_EN macro.
module q_result_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int Q_WIDTH    = 2*DATA_WIDTH+3,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  q_result_fifo_if.slave             bus,
  input  logic                       clear_ovf,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
`ifdef Q_FIFO_STATS_EN
  ,
  output logic [31:0]                stat_cnt,
  output logic signed [Q_WIDTH-1:0]  stat_min,
  output logic signed [Q_WIDTH-1:0]  stat_max
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (Q_WIDTH != 2*DATA_WIDTH+3) begin : g_width_check
    $error("q_result_fifo: Q_WIDTH must equal 2*DATA_WIDTH+3");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH-1)) != 0) begin : g_depth_check
    $error("q_result_fifo: DEPTH must be a power of two, at least 2");
  end

  logic [Q_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic [CW-1:0]      count_r;
  logic [CW-1:0]      count_next;
  logic               full_r;
  logic               empty_r;
  logic               ovf_r;
  logic               push;
  logic               pop;
  logic               drop;

  // A pop frees the slot a same-cycle push needs, so a full FIFO can still accept.
  always_comb begin
    pop        = bus.out_ready && !empty_r;
    push       = bus.in_valid && (!full_r || pop);
    drop       = bus.in_valid && full_r && !pop;
    count_next = count_r;
    if (push && !pop) begin
      count_next = count_r + CW'(1);
    end else if (pop && !push) begin
      count_next = count_r - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= bus.in_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      ovf_r   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count_r <= count_next;
      full_r  <= (count_next == CW'(DEPTH));
      empty_r <= (count_next == '0);
      // A new drop wins over a simultaneous clear.
      if (drop) begin
        ovf_r <= 1'b1;
      end else if (clear_ovf) begin
        ovf_r <= 1'b0;
      end
    end
  end

  assign bus.out_valid = !empty_r;
  assign bus.out_q     = mem[rd_ptr];
  assign count         = count_r;
  assign full          = full_r;
  assign empty         = empty_r;
  assign overflow      = ovf_r;

`ifdef Q_FIFO_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cnt <= '0;
      stat_min <= {1'b0, {(Q_WIDTH-1){1'b1}}};
      stat_max <= {1'b1, {(Q_WIDTH-1){1'b0}}};
    end else if (push) begin
      if (stat_cnt != '1) begin
        stat_cnt <= stat_cnt + 32'd1;
      end
      if ($signed(bus.in_q) < stat_min) begin
        stat_min <= $signed(bus.in_q);
      end
      if ($signed(bus.in_q) > stat_max) begin
        stat_max <= $signed(bus.in_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_q_result_fifo.sv
// Self-checking bench for q_result_fifo: directed vector table, hand sequences, and
// randomized traffic against a queue-based reference model.
module tb_q_result_fifo;

  localparam int DW    = 16;
  localparam int QW    = 2*DW+3;
  localparam int DEPTH = 8;
  localparam longint QMAX = (longint'(1) <<< (QW-1)) - 1;
  localparam longint QMIN = -(longint'(1) <<< (QW-1));

  logic                      clk;
  logic                      rst;
  logic                      clear_ovf;
  logic [$clog2(DEPTH):0]    count;
  logic                      full;
  logic                      empty;
  logic                      overflow;
`ifdef Q_FIFO_STATS_EN
  logic [31:0]               stat_cnt;
  logic signed [QW-1:0]      stat_min;
  logic signed [QW-1:0]      stat_max;
`endif

  q_result_fifo_if #(.Q_WIDTH(QW)) bus ();

  q_result_fifo #(
    .DATA_WIDTH(DW),
    .Q_WIDTH   (QW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .clear_ovf(clear_ovf),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
`ifdef Q_FIFO_STATS_EN
    ,
    .stat_cnt (stat_cnt),
    .stat_min (stat_min),
    .stat_max (stat_max)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          iv;
    logic [QW-1:0] q;
    logic          rdy;
    logic          clr;
    int            exp_count;
    logic          exp_valid;
    logic [QW-1:0] exp_q;
    logic          exp_ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: a plain queue plus flags, advanced once per clock edge.
  logic [QW-1:0]        mq[$];
  bit                   m_ovf = 1'b0;
  logic [31:0]          m_cnt = '0;
  logic signed [QW-1:0] m_min = QW'(QMAX);
  logic signed [QW-1:0] m_max = QW'(QMIN);

  function automatic logic [QW-1:0] qv(input longint v);
    return v[QW-1:0];
  endfunction

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void add(input bit r, input bit iv, input longint qd, input bit rdy, input bit clr,
                              input int c, input bit v, input longint eq, input bit ov);
    vec_t t;
    t.rst = r; t.iv = iv; t.q = qv(qd); t.rdy = rdy; t.clr = clr;
    t.exp_count = c; t.exp_valid = v; t.exp_q = qv(eq); t.exp_ovf = ov;
    vecs.push_back(t);
  endfunction

  task automatic applyStimulus(input logic r, input logic iv, input logic [QW-1:0] q,
                               input logic rdy, input logic clr);
    bit do_pop;
    bit do_push;
    rst           = r;
    bus.in_valid  = iv;
    bus.in_q      = q;
    bus.out_ready = rdy;
    clear_ovf     = clr;
    if (r) begin
      mq.delete();
      m_ovf = 1'b0;
      m_cnt = '0;
      m_min = QW'(QMAX);
      m_max = QW'(QMIN);
    end else begin
      do_pop  = rdy && (mq.size() > 0);
      do_push = iv && ((mq.size() < DEPTH) || do_pop);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(q);
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        if ($signed(q) < m_min) m_min = $signed(q);
        if ($signed(q) > m_max) m_max = $signed(q);
      end
      if (iv && !do_push) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, " count"}, 64'(count), 64'(mq.size()));
    check({tag, " out_valid"}, 64'(bus.out_valid), 64'(mq.size() > 0));
    check({tag, " full"}, 64'(full), 64'(mq.size() == DEPTH));
    check({tag, " empty"}, 64'(empty), 64'(mq.size() == 0));
    check({tag, " overflow"}, 64'(overflow), 64'(m_ovf));
    if (mq.size() > 0) check({tag, " out_q"}, 64'(bus.out_q), 64'(mq[0]));
`ifdef Q_FIFO_STATS_EN
    check({tag, " stat_cnt"}, 64'(stat_cnt), 64'(m_cnt));
    check({tag, " stat_min"}, 64'(stat_min), 64'(m_min));
    check({tag, " stat_max"}, 64'(stat_max), 64'(m_max));
`endif
  endtask

  initial begin
    logic [63:0] rnd;
    logic [QW-1:0] d;
    int rdy_pct;
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_q = '0; bus.out_ready = 1'b0; clear_ovf = 1'b0;

    // Reset with a push pending, then ordering through the FIFO.
    add(1,1,5,0,0, 0,0,0,0);
    add(1,1,5,0,0, 0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0);
    add(0,1,11,0,0, 1,1,11,0);
    add(0,1,-64,0,0, 2,1,11,0);
    add(0,1,74850,0,0, 3,1,11,0);
    add(0,0,0,1,0, 2,1,-64,0);
    add(0,0,0,1,0, 1,1,74850,0);
    add(0,0,0,1,0, 0,0,0,0);
    add(0,0,0,1,0, 0,0,0,0);
    add(0,1,7,1,0, 1,1,7,0);
    add(0,0,0,1,0, 0,0,0,0);
    // Fill, drop, drain, clear.
    for (int i = 1; i <= DEPTH; i++) add(0,1,i,0,0, i,1,1,0);
    add(0,1,999,0,0, 8,1,1,1);
    for (int i = 1; i <= DEPTH; i++) add(0,0,0,1,0, 8-i,(i<8),i+1,1);
    add(0,0,0,0,1, 0,0,0,0);
    // Push and pop together while full.
    for (int i = 1; i <= DEPTH; i++) add(0,1,i,0,0, i,1,1,0);
    add(0,1,42,1,0, 8,1,2,0);
    for (int k = 1; k <= DEPTH; k++) add(0,0,0,1,0, 8-k,(k<8),(k<=6) ? k+2 : 42,0);
    // Drop wins over clear, then reset mid-operation.
    for (int i = 1; i <= DEPTH; i++) add(0,1,i,0,0, i,1,1,0);
    add(0,1,5,0,0, 8,1,1,1);
    add(0,1,6,0,1, 8,1,1,1);
    add(0,0,0,0,1, 8,1,1,0);
    add(1,1,9,1,1, 0,0,0,0);
    // Extreme values.
    add(0,1,QMIN,0,0, 1,1,QMIN,0);
    add(0,1,QMAX,0,0, 2,1,QMIN,0);
    add(0,1,3,1,0, 2,1,QMAX,0);
    add(0,0,0,1,0, 1,1,3,0);
    add(0,0,0,1,0, 0,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      applyStimulus(vecs[i].rst, vecs[i].iv, vecs[i].q, vecs[i].rdy, vecs[i].clr);
      checkOutput(tag);
      check({tag, " tbl_count"}, 64'(count), 64'(vecs[i].exp_count));
      check({tag, " tbl_valid"}, 64'(bus.out_valid), 64'(vecs[i].exp_valid));
      check({tag, " tbl_ovf"}, 64'(overflow), 64'(vecs[i].exp_ovf));
      if (vecs[i].exp_valid) check({tag, " tbl_q"}, 64'(bus.out_q), 64'(vecs[i].exp_q));
    end

    // No bypass: a push into an empty FIFO is invisible until after its edge.
    bus.in_valid = 1'b1; bus.in_q = qv(123); bus.out_ready = 1'b0;
    #2;
    check("nobypass before_edge", 64'(bus.out_valid), 64'(0));
    applyStimulus(0, 1, qv(123), 0, 0);
    check("nobypass after_edge", 64'(bus.out_valid), 64'(1));
    check("nobypass q", 64'(bus.out_q), 64'(qv(123)));
    checkOutput("nobypass");

`ifdef Q_FIFO_STATS_EN
    applyStimulus(1, 0, '0, 0, 0);
    applyStimulus(0, 1, qv(11), 0, 0);
    applyStimulus(0, 1, qv(-64), 0, 0);
    applyStimulus(0, 1, qv(74850), 0, 0);
    check("stats cnt3", 64'(stat_cnt), 64'(3));
    check("stats min", 64'(stat_min), 64'(qv(-64)));
    check("stats max", 64'(stat_max), 64'(qv(74850)));
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, qv(i), 0, 0);
    applyStimulus(0, 1, qv(1000000), 0, 0);
    check("stats drop_max", 64'(stat_max), 64'(qv(74850)));
    check("stats drop_cnt", 64'(stat_cnt), 64'(8));
    applyStimulus(1, 1, qv(77), 1, 0);
    check("stats rst_cnt", 64'(stat_cnt), 64'(0));
    checkOutput("stats");
`endif

    // Randomized traffic, alternating fill-biased and drain-biased phases.
    applyStimulus(1, 0, '0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      rdy_pct = ((c / 250) % 2 == 0) ? 30 : 75;
      rnd = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0:       d = qv(QMIN);
        1:       d = qv(QMAX);
        default: d = rnd[QW-1:0];
      endcase
      applyStimulus(($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 99) < 60),
                    d,
                    ($urandom_range(0, 99) < rdy_pct),
                    ($urandom_range(0, 9) == 0));
      checkOutput($sformatf("rnd%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/q_result_fifo.md
Name: q_result_fifo

Overview:
Downstream stage of the Q datapath. Captures each signed Q result on the producer's output_valid strobe and buffers it in a small first-word-fall-through FIFO. Results are released to the consumer over a valid/ready handshake. The producer cannot be back-pressured, so results arriving while the FIFO is full are dropped and a sticky overflow flag is raised.

Parameters:
DATA_WIDTH, 16, operand width of the Q producer.
Q_WIDTH, 2*DATA_WIDTH+3, signed result width. Must match the producer's Q port (35 at default).
DEPTH, 8, FIFO entries. Power of two, at least 2.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  result strobe, driven by the producer's output_valid
in_q  in  Q_WIDTH  signed result, sampled when in_valid=1
out_valid  out  1  head entry available
out_ready  in  1  consumer accepts the head entry
out_q  out  Q_WIDTH  signed head entry
count  out  $clog2(DEPTH)+1  number of stored entries
full  out  1  count==DEPTH
empty  out  1  count==0
overflow  out  1  sticky: a push was dropped
clear_ovf  in  1  clears overflow

Behaviour:
- Reset and clock: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - rd/wr pointers = 0, count = 0, out_valid = 0, empty = 1, full = 0, overflow = 0.
  - out_q don't-care while out_valid = 0.
  - Storage array is not reset.
- Push: in_valid=1 at a rising edge writes in_q at wr_ptr, and wr_ptr increments modulo DEPTH.
  - A push is accepted if full=0, or if a pop occurs in the same cycle.
- Pop: out_valid & out_ready at a rising edge advances rd_ptr modulo DEPTH.
  - out_ready while empty is ignored.
- FWFT rules:
  - out_valid = !empty.
  - out_q = mem[rd_ptr], a combinational read of the registered array.
  - No bypass: a push into an empty FIFO becomes visible one cycle later (out_valid rises the cycle after the accepting edge).
- Count update: +1 on push only, -1 on pop only, unchanged on push+pop.
  - full and empty are derived from count and registered with it.
- Simultaneous push+pop:
  - Empty: push stored, pop ignored, count becomes 1.
  - Full: both take effect, count stays DEPTH, no overflow.
- Overflow: in_valid=1 while full=0 would be required but no pop occurs, i.e. full with no pop.
  - in_q is discarded; pointers and count are unchanged; overflow is set.
  - clear_ovf=1 clears overflow on the next edge.
  - If clear_ovf and a new drop occur in the same cycle, overflow stays 1 (set wins).
- Data integrity: values stored and returned bit-exact, with no sign handling or truncation.
  - Full range -2^(Q_WIDTH-1) .. 2^(Q_WIDTH-1)-1.
- Wrap-around: pointers wrap silently; ordering is preserved across wrap.
- Reset mid-operation: rst has priority over push/pop/clear in the same cycle.
  - All stored entries are discarded logically (count = 0).

Optional Feature:
- Q_FIFO_STATS_EN.
- When defined, adds three outputs, all updated on every accepted push:
  - stat_cnt: 32-bit count of accepted results, saturating at 2^32-1.
  - stat_min: Q_WIDTH signed minimum; reset value is the most positive value.
  - stat_max: Q_WIDTH signed maximum; reset value is the most negative value.
- Dropped pushes do not update the statistics. rst reinitialises them.
- When undefined, these ports and their logic do not exist, and the FIFO behaviour is identical.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with in_valid=1, in_q=5 -> count=0, empty=1, out_valid=0, overflow=0 after release.
2. Ordering: push 11, -64, 74850 with out_ready=0 -> count=3, out_q=11. Then out_ready=1 for 3 cycles -> out_q 11, -64, 74850, then empty=1, count=0.
3. Overflow: DEPTH=8, push 1..8 with out_ready=0 -> full=1. Push 999 -> overflow=1, count=8, and draining yields 1..8 only. Pulse clear_ovf -> overflow=0.
4. Full push+pop: with FIFO full of 1..8, push 42 with out_ready=1 in the same cycle -> count=8, overflow=0. Drain yields 2..8, then 42.
5. Wrap and extremes: 20 interleaved push/pop cycles through pointer wrap, including -2^34 and 2^34-1 -> output order and values bit-exact. Push into empty -> out_valid rises exactly one cycle after the push edge.
6. Stats (Q_FIFO_STATS_EN): push 11, -64, 74850 -> stat_cnt=3, stat_min=-64, stat_max=74850. An overflow-dropped push of 10^6 leaves stat_max unchanged. rst mid-stream -> stat_cnt=0.
